// File: rtl/iic_eeprom_seq.sv
// Transaction sequencer for the EEPROM I2C byte engine.
// Turns write/read key requests into byte-level engine commands, enforces the
// EEPROM write-cycle time, retries NACKed transactions and reports the byte read back.
module iic_eeprom_seq #(
   parameter int         CLK_FREQ  = 50_000_000,
   parameter logic [6:0] DEV_ADDR  = 7'h50,
   parameter logic [7:0] WORD_ADDR = 8'h00,
   parameter int         TWR_US    = 5000,
   parameter int         MAX_RETRY = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_req,
   input  logic       rd_req,
   input  logic [7:0] wr_data,
   output logic [2:0] cmd,
   output logic [7:0] cmd_byte,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   input  logic       eng_done,
   input  logic       eng_ack_n,
   input  logic [7:0] eng_rx,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       busy,
   output logic       err
);

   // Write-cycle wait length in clock cycles (at least one cycle).
   localparam int TWR_CYC_RAW = (CLK_FREQ / 1_000_000) * TWR_US;
   localparam int TWR_CYC     = (TWR_CYC_RAW < 1) ? 1 : TWR_CYC_RAW;
   localparam int CW          = $clog2(TWR_CYC + 1);
   localparam int RW          = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   localparam logic [CW-1:0] TWR_LAST  = CW'(TWR_CYC - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

   localparam logic [2:0] CMD_START_WR = 3'd1;
   localparam logic [2:0] CMD_WR       = 3'd2;
   localparam logic [2:0] CMD_RD_STOP  = 3'd3;
   localparam logic [2:0] CMD_STOP     = 3'd4;

   localparam logic [7:0] DEV_WR_BYTE = {DEV_ADDR, 1'b0};
   localparam logic [7:0] DEV_RD_BYTE = {DEV_ADDR, 1'b1};

   typedef enum logic [3:0] {
      IDLE,
      W_DEV,
      W_ADDR,
      W_DATA,
      W_STOP,
      TWR_WAIT,
      R_DEV,
      R_ADDR,
      R_RDEV,
      R_READ,
      ABORT_STOP
   } state_t;

   state_t          state_reg;
   logic            wr_pend_reg;
   logic            rd_pend_reg;
   logic [7:0]      wdat_reg;
   logic [7:0]      cur_dat_reg;   // byte of the write in flight, kept across retries
   logic            is_wr_reg;     // transaction in flight is a write
   logic [RW-1:0]   retry_cnt_reg;
   logic [CW-1:0]   twr_cnt_reg;

   assign busy = (state_reg != IDLE);

   // Request capture, arbitration and command sequencing with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         wr_pend_reg   <= 1'b0;
         rd_pend_reg   <= 1'b0;
         wdat_reg      <= 8'h00;
         cur_dat_reg   <= 8'h00;
         is_wr_reg     <= 1'b0;
         retry_cnt_reg <= '0;
         twr_cnt_reg   <= '0;
         cmd           <= 3'd0;
         cmd_byte      <= 8'h00;
         cmd_valid     <= 1'b0;
         rd_data       <= 8'h00;
         rd_valid      <= 1'b0;
         err           <= 1'b0;
      end else begin
         rd_valid <= 1'b0;

         // A pulse that finds its flag already set is dropped.
         if (wr_req && !wr_pend_reg) begin
            wr_pend_reg <= 1'b1;
            wdat_reg    <= wr_data;
         end
         if (rd_req && !rd_pend_reg) begin
            rd_pend_reg <= 1'b1;
         end

         case (state_reg)
            IDLE: begin
               if (wr_pend_reg) begin
                  wr_pend_reg <= 1'b0;
                  is_wr_reg   <= 1'b1;
                  cur_dat_reg <= wdat_reg;
                  err         <= 1'b0;
                  state_reg   <= W_DEV;
                  cmd         <= CMD_START_WR;
                  cmd_byte    <= DEV_WR_BYTE;
                  cmd_valid   <= 1'b1;
               end else if (rd_pend_reg) begin
                  rd_pend_reg <= 1'b0;
                  is_wr_reg   <= 1'b0;
                  err         <= 1'b0;
                  state_reg   <= R_DEV;
                  cmd         <= CMD_START_WR;
                  cmd_byte    <= DEV_WR_BYTE;
                  cmd_valid   <= 1'b1;
               end
            end

            TWR_WAIT: begin
               if (twr_cnt_reg == TWR_LAST) begin
                  state_reg <= IDLE;
               end else begin
                  twr_cnt_reg <= twr_cnt_reg + 1'b1;
               end
            end

            default: begin
               if (cmd_valid) begin
                  // Hold the command until the engine takes it.
                  if (cmd_ready) begin
                     cmd_valid <= 1'b0;
                     cmd       <= 3'd0;
                     cmd_byte  <= 8'h00;
                  end
               end else if (eng_done) begin
                  // NACK on an address/data byte aborts the transaction with a STOP.
                  if (eng_ack_n && (state_reg == W_DEV || state_reg == W_ADDR ||
                                    state_reg == W_DATA || state_reg == R_DEV ||
                                    state_reg == R_ADDR || state_reg == R_RDEV)) begin
                     state_reg <= ABORT_STOP;
                     cmd       <= CMD_STOP;
                     cmd_byte  <= 8'h00;
                     cmd_valid <= 1'b1;
                  end else begin
                     case (state_reg)
                        W_DEV: begin
                           state_reg <= W_ADDR;
                           cmd       <= CMD_WR;
                           cmd_byte  <= WORD_ADDR;
                           cmd_valid <= 1'b1;
                        end
                        W_ADDR: begin
                           state_reg <= W_DATA;
                           cmd       <= CMD_WR;
                           cmd_byte  <= cur_dat_reg;
                           cmd_valid <= 1'b1;
                        end
                        W_DATA: begin
                           state_reg <= W_STOP;
                           cmd       <= CMD_STOP;
                           cmd_byte  <= 8'h00;
                           cmd_valid <= 1'b1;
                        end
                        W_STOP: begin
                           state_reg     <= TWR_WAIT;
                           twr_cnt_reg   <= '0;
                           retry_cnt_reg <= '0;
                        end
                        R_DEV: begin
                           state_reg <= R_ADDR;
                           cmd       <= CMD_WR;
                           cmd_byte  <= WORD_ADDR;
                           cmd_valid <= 1'b1;
                        end
                        R_ADDR: begin
                           state_reg <= R_RDEV;
                           cmd       <= CMD_START_WR;
                           cmd_byte  <= DEV_RD_BYTE;
                           cmd_valid <= 1'b1;
                        end
                        R_RDEV: begin
                           state_reg <= R_READ;
                           cmd       <= CMD_RD_STOP;
                           cmd_byte  <= 8'h00;
                           cmd_valid <= 1'b1;
                        end
                        R_READ: begin
                           state_reg     <= IDLE;
                           rd_data       <= eng_rx;
                           rd_valid      <= 1'b1;
                           retry_cnt_reg <= '0;
                        end
                        ABORT_STOP: begin
                           if (retry_cnt_reg < RETRY_MAX) begin
                              retry_cnt_reg <= retry_cnt_reg + 1'b1;
                              state_reg     <= is_wr_reg ? W_DEV : R_DEV;
                              cmd           <= CMD_START_WR;
                              cmd_byte      <= DEV_WR_BYTE;
                              cmd_valid     <= 1'b1;
                           end else begin
                              err           <= 1'b1;
                              retry_cnt_reg <= '0;
                              state_reg     <= IDLE;
                           end
                        end
                        default: begin
                           state_reg <= IDLE;
                        end
                     endcase
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iic_eeprom_seq.sv
// Directed testbench for iic_eeprom_seq with a bench-side byte engine responder.
// The write-cycle wait is shortened to 20 cycles (1 MHz clock, 20 us).
module tb_iic_eeprom_seq;

   localparam int TWR_CYC = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_req = 1'b0;
   logic       rd_req = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic [2:0] cmd;
   logic [7:0] cmd_byte;
   logic       cmd_valid;
   logic       cmd_ready = 1'b0;
   logic       eng_done = 1'b0;
   logic       eng_ack_n = 1'b0;
   logic [7:0] eng_rx = 8'h00;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       busy;
   logic       err;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   iic_eeprom_seq #(
      .CLK_FREQ (1_000_000),
      .DEV_ADDR (7'h50),
      .WORD_ADDR(8'h00),
      .TWR_US   (20),
      .MAX_RETRY(3)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_req   (wr_req),
      .rd_req   (rd_req),
      .wr_data  (wr_data),
      .cmd      (cmd),
      .cmd_byte (cmd_byte),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .eng_done (eng_done),
      .eng_ack_n(eng_ack_n),
      .eng_rx   (eng_rx),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .busy     (busy),
      .err      (err)
   );

   // Engine model: waits (bounded) for a command, accepts it, then reports done.
   // Returns at the negedge right after the eng_done clock edge.
   task automatic serve_cmd(input logic ack_n, input logic [7:0] rx,
                            output logic [10:0] got, output logic ok);
      ok  = 1'b0;
      got = '0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cmd_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         got = {cmd, cmd_byte};
         cmd_ready = 1'b1;
         @(negedge clk);
         cmd_ready = 1'b0;
         @(negedge clk);
         eng_ack_n = ack_n;
         eng_rx    = rx;
         eng_done  = 1'b1;
         @(negedge clk);
         eng_done  = 1'b0;
         eng_ack_n = 1'b0;
         eng_rx    = 8'h00;
         $display("engine: cmd %0d byte %h ack_n %0d", got[10:8], got[7:0], ack_n);
      end else begin
         $display("engine: no command offered");
      end
   endtask

   // Counts negedges until busy drops (bounded).
   task automatic count_busy(output int n);
      n = 0;
      while (busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks++;
      if ({cmd, cmd_byte, cmd_valid, rd_data, rd_valid, busy, err} !== 22'd0) begin
         $display("FAIL reset_outputs: got %h, expected 0",
                  {cmd, cmd_byte, cmd_valid, rd_data, rd_valid, busy, err});
         fails++;
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         $display("FAIL reset_idle: busy=%b, expected 0", busy);
         fails++;
      end
      $display("reset done");
   endtask

   task automatic test_write;
      logic [10:0] exp_c [0:3];
      logic [10:0] got;
      logic        ok;
      int          n;
      exp_c = '{11'h1A0, 11'h200, 11'h2A5, 11'h400};
      @(negedge clk);
      wr_data = 8'hA5;
      wr_req  = 1'b1;
      @(negedge clk);
      wr_req  = 1'b0;
      wr_data = 8'h00;
      for (int i = 0; i < 4; i++) begin
         serve_cmd(1'b0, 8'h00, got, ok);
         checks++;
         if (!ok || got !== exp_c[i]) begin
            $display("FAIL write_cmd%0d: got %h ok=%0d, expected %h", i, got, ok, exp_c[i]);
            fails++;
         end
      end
      count_busy(n);
      checks++;
      if (n !== TWR_CYC) begin
         $display("FAIL write_twr: busy cycles %0d, expected %0d", n, TWR_CYC);
         fails++;
      end
      checks++;
      if (err !== 1'b0) begin
         $display("FAIL write_err: err=%b, expected 0", err);
         fails++;
      end
      $display("write A5 done, twr %0d cycles", n);
   endtask

   task automatic test_read;
      logic [10:0] exp_c [0:3];
      logic [10:0] got;
      logic        ok;
      exp_c = '{11'h1A0, 11'h200, 11'h1A1, 11'h300};
      @(negedge clk);
      rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         serve_cmd(1'b0, 8'h3C, got, ok);
         checks++;
         if (!ok || got !== exp_c[i]) begin
            $display("FAIL read_cmd%0d: got %h ok=%0d, expected %h", i, got, ok, exp_c[i]);
            fails++;
         end
      end
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h3C) begin
         $display("FAIL read_data: rd_valid=%b rd_data=%h, expected 1/3c", rd_valid, rd_data);
         fails++;
      end
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL read_pulse: rd_valid=%b busy=%b, expected 0/0", rd_valid, busy);
         fails++;
      end
      $display("read 3C done");
   endtask

   task automatic test_simultaneous;
      logic [10:0] exp_c [0:7];
      logic [10:0] got;
      logic        ok;
      int          n;
      exp_c = '{11'h1A0, 11'h200, 11'h25A, 11'h400,
                11'h1A0, 11'h200, 11'h1A1, 11'h300};
      @(negedge clk);
      wr_data = 8'h5A;
      wr_req  = 1'b1;
      rd_req  = 1'b1;
      @(negedge clk);
      wr_req  = 1'b0;
      rd_req  = 1'b0;
      wr_data = 8'h00;
      for (int i = 0; i < 4; i++) begin
         serve_cmd(1'b0, 8'h00, got, ok);
         checks++;
         if (!ok || got !== exp_c[i]) begin
            $display("FAIL simul_cmd%0d: got %h ok=%0d, expected %h", i, got, ok, exp_c[i]);
            fails++;
         end
      end
      count_busy(n);
      checks++;
      if (n !== TWR_CYC) begin
         $display("FAIL simul_twr: busy cycles %0d, expected %0d", n, TWR_CYC);
         fails++;
      end
      for (int i = 4; i < 8; i++) begin
         serve_cmd(1'b0, 8'hC3, got, ok);
         checks++;
         if (!ok || got !== exp_c[i]) begin
            $display("FAIL simul_cmd%0d: got %h ok=%0d, expected %h", i, got, ok, exp_c[i]);
            fails++;
         end
      end
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'hC3) begin
         $display("FAIL simul_data: rd_valid=%b rd_data=%h, expected 1/c3", rd_valid, rd_data);
         fails++;
      end
      $display("simultaneous write 5A then read C3 done");
   endtask

   task automatic test_retry;
      logic [10:0] exp_c [0:7];
      logic        acks  [0:7];
      logic [10:0] got;
      logic        ok;
      int          n;
      exp_c = '{11'h1A0, 11'h400, 11'h1A0, 11'h400,
                11'h1A0, 11'h200, 11'h277, 11'h400};
      acks  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      @(negedge clk);
      wr_data = 8'h77;
      wr_req  = 1'b1;
      @(negedge clk);
      wr_req  = 1'b0;
      wr_data = 8'h00;
      for (int i = 0; i < 8; i++) begin
         serve_cmd(acks[i], 8'h00, got, ok);
         checks++;
         if (!ok || got !== exp_c[i]) begin
            $display("FAIL retry_cmd%0d: got %h ok=%0d, expected %h", i, got, ok, exp_c[i]);
            fails++;
         end
      end
      count_busy(n);
      checks++;
      if (n !== TWR_CYC || err !== 1'b0) begin
         $display("FAIL retry_end: twr %0d err=%b, expected %0d/0", n, err, TWR_CYC);
         fails++;
      end
      $display("retry write 77 done");
   endtask

   task automatic test_error;
      logic [10:0] got;
      logic [10:0] exp_v;
      logic        ok;
      @(negedge clk);
      wr_data = 8'h11;
      wr_req  = 1'b1;
      @(negedge clk);
      wr_req  = 1'b0;
      wr_data = 8'h00;
      for (int i = 0; i < 8; i++) begin
         exp_v = (i % 2 == 0) ? 11'h1A0 : 11'h400;
         serve_cmd((i % 2 == 0), 8'h00, got, ok);
         checks++;
         if (!ok || got !== exp_v) begin
            $display("FAIL error_cmd%0d: got %h ok=%0d, expected %h", i, got, ok, exp_v);
            fails++;
         end
      end
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         $display("FAIL error_flag: err=%b busy=%b, expected 1/0", err, busy);
         fails++;
      end
      repeat (TWR_CYC + 5) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || err !== 1'b1) begin
         $display("FAIL error_no_twr: busy=%b err=%b, expected 0/1", busy, err);
         fails++;
      end
      rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         $display("FAIL error_clear: err=%b busy=%b, expected 0/1", err, busy);
         fails++;
      end
      $display("error after 4 attempts, cleared by read");
   endtask

   // Continues the read started by test_error.
   task automatic test_backpressure_reset;
      logic [10:0] c0;
      logic [10:0] got;
      logic        ok;
      logic        stable;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (cmd_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      c0 = {cmd, cmd_byte};
      stable = ok;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (cmd_valid !== 1'b1 || {cmd, cmd_byte} !== c0) stable = 1'b0;
      end
      checks++;
      if (!stable || c0 !== 11'h1A0) begin
         $display("FAIL bp_stable: first %h stable=%0d, now %h valid=%b, expected 1a0 held",
                  c0, stable, {cmd, cmd_byte}, cmd_valid);
         fails++;
      end
      serve_cmd(1'b0, 8'h00, got, ok);
      checks++;
      if (!ok || got !== 11'h1A0) begin
         $display("FAIL bp_rdev_cmd: got %h ok=%0d, expected 1a0", got, ok);
         fails++;
      end
      serve_cmd(1'b0, 8'h00, got, ok);
      checks++;
      if (!ok || got !== 11'h200) begin
         $display("FAIL bp_raddr_cmd: got %h ok=%0d, expected 200", got, ok);
         fails++;
      end
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cmd_valid) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok || {cmd, cmd_byte} !== 11'h1A1) begin
         $display("FAIL bp_rrdev_cmd: got %h ok=%0d, expected 1a1", {cmd, cmd_byte}, ok);
         fails++;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({cmd, cmd_byte, cmd_valid, rd_data, rd_valid, busy, err} !== 22'd0) begin
         $display("FAIL midreset_outputs: got %h, expected 0",
                  {cmd, cmd_byte, cmd_valid, rd_data, rd_valid, busy, err});
         fails++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
         $display("FAIL midreset_idle: busy=%b cmd_valid=%b, expected 0/0", busy, cmd_valid);
         fails++;
      end
      $display("backpressure and reset during R_RDEV done");
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_simultaneous();
      test_retry();
      test_error();
      test_backpressure_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/iic_eeprom_seq.md
Name: iic_eeprom_seq

Overview:
Transaction sequencer for the EEPROM I2C byte engine. Accepts single-cycle write/read requests from the debounced keys and arbitrates between them. Breaks each request into byte-level engine commands with a valid/ready handshake. Enforces the EEPROM write-cycle time, retries NACKed transactions, and presents the read-back byte to the seg7 display path.

Parameters:
CLK_FREQ, 50_000_000, system clock in Hz
DEV_ADDR, 7'h50, 7-bit EEPROM device address
WORD_ADDR, 8'h00, fixed EEPROM word address
TWR_US, 5000, post-write wait in microseconds before any new transaction
MAX_RETRY, 3, retries after NACK before error is flagged

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_req  in  1  write request pulse (debounced key_wr)
rd_req  in  1  read request pulse (debounced key_rd)
wr_data  in  8  byte to write, sampled when wr_req is accepted
cmd  out  3  engine command: 1=START+WRITE, 2=WRITE, 3=READ+NACK+STOP, 4=STOP
cmd_byte  out  8  byte sent with cmd 1/2; 0 otherwise
cmd_valid  out  1  command valid
cmd_ready  in  1  engine accepts command
eng_done  in  1  one-cycle pulse, command finished
eng_ack_n  in  1  slave ACK bit for cmd 1/2, valid with eng_done (1=NACK)
eng_rx  in  8  received byte, valid with eng_done after cmd 3
rd_data  out  8  last byte read
rd_valid  out  1  one-cycle pulse when rd_data updates
busy  out  1  high in any state other than IDLE
err  out  1  sticky error flag (drives led); cleared by next accepted request

Behaviour:
- Reset values: all outputs 0; state IDLE; pending flags, latched data and retry counter cleared. Reset mid-transaction aborts immediately, with no STOP issued.
- Request capture: wr_req/rd_req set pending flags wr_pend/rd_pend in any state. A pulse that arrives while the same flag is already set is dropped. wr_data is latched into wdat on the wr_req pulse; a later wr_req overwrites wdat only while wr_pend=0.
- Arbitration in IDLE: wr_pend has priority over rd_pend; a simultaneous pulse serves the write first, then the read. The pending flag is cleared on the transition out of IDLE. err clears on the same transition.
- Handshake: cmd/cmd_byte are held stable while cmd_valid=1. The command is transferred on a cycle where cmd_valid&&cmd_ready. cmd_valid drops the next cycle and the FSM waits for eng_done. Only one command is outstanding at a time.
- Write sequence:
  - W_DEV: cmd1, byte {DEV_ADDR,0}
  - W_ADDR: cmd2, byte WORD_ADDR
  - W_DATA: cmd2, byte wdat
  - W_STOP: cmd4
  - TWR_WAIT: counter runs CLK_FREQ/1_000_000*TWR_US cycles, then IDLE.
- Read sequence (random read):
  - R_DEV: cmd1, byte {DEV_ADDR,0}
  - R_ADDR: cmd2, byte WORD_ADDR
  - R_RDEV: cmd1 (repeated start), byte {DEV_ADDR,1}
  - R_READ: cmd3. On eng_done: rd_data<=eng_rx, rd_valid pulses for 1 cycle, then IDLE. No TWR wait after a read.
- NACK handling: eng_ack_n=1 on any cmd1/cmd2 completion goes to ABORT_STOP, which issues cmd4.
  - If retry_cnt<MAX_RETRY: increment retry_cnt and restart the same transaction at its first state. wdat is preserved.
  - Otherwise: set err, clear retry_cnt, go to IDLE. A write that fails this way does not enter TWR_WAIT.
  - retry_cnt clears on successful completion of a transaction.
- A new request arriving during TWR_WAIT stays pending and is served after the wait expires.
- eng_done arriving while not waiting for it is ignored.

Test Plan:
- Write: wr_data=8'hA5, wr_req pulse, engine always ACKs. Command stream is (1,A0),(2,00),(2,A5),(4). busy stays high for a further 250_000 cycles after the STOP done, then IDLE.
- Read: rd_req pulse, engine returns eng_rx=8'h3C. Command stream is (1,A0),(2,00),(1,A1),(3). rd_data=3C and rd_valid is high for exactly 1 cycle.
- Simultaneous: wr_req and rd_req pulsed in the same cycle. The full write, including the 250_000-cycle wait, completes first, then the read.
- Retry: first cmd1 is NACKed twice, then ACKed. Command stream is (1,A0),(4),(1,A0),(4),(1,A0),... The write completes with err=0.
- Error: every cmd1 is NACKed. After 4 attempts (1 + MAX_RETRY), err=1 and the FSM is in IDLE. A following rd_req clears err.
- Backpressure and reset: hold cmd_ready=0 for 10 cycles; cmd/cmd_byte must stay stable. Assert rst_n=0 during R_RDEV; all outputs must be 0 and the FSM in IDLE immediately.
